// File: rtl/address_gen_unit.sv
// address_gen_unit: sequences weight, input-tile, conv-window and drain buffer addresses.
// Optional macro AGU_BOUNDS_CHECK_EN adds the sticky agu_err output and the addr >= N*N check.
//
// state  | meaning
// S_IDLE | waiting for agu_start; configuration latched on start
// S_RUN  | presenting addresses, advancing on each accepted handshake
// S_FIN  | one-cycle agu_done pulse, then back to S_IDLE
module address_gen_unit #(
  parameter int MAX_N      = 64,
  parameter int MAX_K      = 16,
  parameter int ARRAY_SIZE = 8,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  agu_start,
  input  logic                  agu_enable,
  input  logic [2:0]            agu_mode,
  input  logic [6:0]            cfg_N,
  input  logic [4:0]            cfg_K,
  input  logic [6:0]            tile_row,
  input  logic [6:0]            tile_col,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  addr_valid,
  input  logic                  addr_ready,
  output logic                  agu_done,
  output logic                  agu_busy
`ifdef AGU_BOUNDS_CHECK_EN
  ,
  output logic                  agu_err
`endif
);

  localparam logic [2:0] MODE_WEIGHT  = 3'd1;
  localparam logic [2:0] MODE_INPUT   = 3'd2;
  localparam logic [2:0] MODE_COMPUTE = 3'd3;
  localparam logic [2:0] MODE_DRAIN   = 3'd4;

  localparam logic [6:0] MAX_N_L = 7'(MAX_N);
  localparam logic [4:0] MAX_K_L = 5'(MAX_K);
  localparam logic [6:0] TILE_L  = 7'(ARRAY_SIZE);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [6:0]            lim0, lim1, lim2, lim3;
  logic [6:0]            c0, c1, c2, c3;
  logic [6:0]            stride_q;
  logic [6:0]            n_q;
  logic [ADDR_WIDTH-1:0] base_row, base_win, base_orow, addr_q;

  logic [6:0]            m_dim, rows_avail, cols_avail, r_lim, c_lim;
  logic [ADDR_WIDTH-1:0] tile_prod, tile_origin;
  logic [6:0]            ld_lim0, ld_lim1, ld_lim2, ld_lim3, ld_stride;
  logic [ADDR_WIDTH-1:0] ld_addr;
  logic                  start_bad, start_hit, fire, last;
  logic                  end0, end1, end2, end3;

  // ---------------- start-time decode ----------------
  assign m_dim       = cfg_N - 7'(cfg_K) + 7'd1;
  assign rows_avail  = cfg_N - tile_row;
  assign cols_avail  = cfg_N - tile_col;
  assign r_lim       = (rows_avail > TILE_L) ? TILE_L : rows_avail;
  assign c_lim       = (cols_avail > TILE_L) ? TILE_L : cols_avail;
  // one multiply, used only when a start is accepted, never per address
  assign tile_prod   = ADDR_WIDTH'(tile_row) * ADDR_WIDTH'(cfg_N);
  assign tile_origin = tile_prod + ADDR_WIDTH'(tile_col);

  always_comb begin
    start_bad = 1'b0;
    if (cfg_N == 7'd0 || cfg_K == 5'd0)  start_bad = 1'b1;
    if (7'(cfg_K) > cfg_N)               start_bad = 1'b1;
    if (cfg_N > MAX_N_L)                 start_bad = 1'b1;
    if (cfg_K > MAX_K_L)                 start_bad = 1'b1;
    if (agu_mode != MODE_WEIGHT && agu_mode != MODE_INPUT &&
        agu_mode != MODE_COMPUTE && agu_mode != MODE_DRAIN)
      start_bad = 1'b1;
    if (agu_mode == MODE_INPUT && (tile_row >= cfg_N || tile_col >= cfg_N))
      start_bad = 1'b1;
  end

  // Every mode is a nest of up to four counters; stride is the row step
  // applied when the innermost counter wraps.
  always_comb begin
    ld_lim0   = 7'(cfg_K);
    ld_lim1   = 7'(cfg_K);
    ld_lim2   = 7'd1;
    ld_lim3   = 7'd1;
    ld_stride = 7'(cfg_K);
    ld_addr   = '0;
    case (agu_mode)
      MODE_INPUT: begin
        ld_lim0   = c_lim;
        ld_lim1   = r_lim;
        ld_stride = cfg_N;
        ld_addr   = tile_origin;
      end
      MODE_COMPUTE: begin
        ld_lim2   = m_dim;
        ld_lim3   = m_dim;
        ld_stride = cfg_N;
      end
      MODE_DRAIN: begin
        ld_lim0   = m_dim;
        ld_lim1   = m_dim;
        ld_stride = m_dim;
      end
      default: ;
    endcase
  end

  assign start_hit = (state == S_IDLE) && agu_start;
  assign fire      = (state == S_RUN) && agu_enable && addr_ready;
  assign end0      = (c0 == lim0 - 7'd1);
  assign end1      = (c1 == lim1 - 7'd1);
  assign end2      = (c2 == lim2 - 7'd1);
  assign end3      = (c3 == lim3 - 7'd1);
  assign last      = end0 && end1 && end2 && end3;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (agu_start) state_nxt = start_bad ? S_FIN : S_RUN;
      S_RUN:  if (fire && last) state_nxt = S_FIN;
      S_FIN:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    addr_valid = (state == S_RUN) && agu_enable;
    agu_busy   = (state == S_RUN);
    agu_done   = (state == S_FIN);
    addr       = addr_q;
  end

  // ---------------- counters and incremental address ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lim0      <= '0;
      lim1      <= '0;
      lim2      <= '0;
      lim3      <= '0;
      c0        <= '0;
      c1        <= '0;
      c2        <= '0;
      c3        <= '0;
      stride_q  <= '0;
      n_q       <= '0;
      base_row  <= '0;
      base_win  <= '0;
      base_orow <= '0;
      addr_q    <= '0;
    end else if (start_hit && !start_bad) begin
      lim0      <= ld_lim0;
      lim1      <= ld_lim1;
      lim2      <= ld_lim2;
      lim3      <= ld_lim3;
      c0        <= '0;
      c1        <= '0;
      c2        <= '0;
      c3        <= '0;
      stride_q  <= ld_stride;
      n_q       <= cfg_N;
      base_row  <= ld_addr;
      base_win  <= '0;
      base_orow <= '0;
      addr_q    <= ld_addr;
    end else if (fire && !last) begin
      if (!end0) begin
        c0     <= c0 + 7'd1;
        addr_q <= addr_q + ADDR_WIDTH'(1);
      end else if (!end1) begin
        c0       <= '0;
        c1       <= c1 + 7'd1;
        base_row <= base_row + ADDR_WIDTH'(stride_q);
        addr_q   <= base_row + ADDR_WIDTH'(stride_q);
      end else if (!end2) begin
        // next conv window along the output row
        c0       <= '0;
        c1       <= '0;
        c2       <= c2 + 7'd1;
        base_win <= base_win + ADDR_WIDTH'(1);
        base_row <= base_win + ADDR_WIDTH'(1);
        addr_q   <= base_win + ADDR_WIDTH'(1);
      end else begin
        c0        <= '0;
        c1        <= '0;
        c2        <= '0;
        c3        <= c3 + 7'd1;
        base_orow <= base_orow + ADDR_WIDTH'(n_q);
        base_win  <= base_orow + ADDR_WIDTH'(n_q);
        base_row  <= base_orow + ADDR_WIDTH'(n_q);
        addr_q    <= base_orow + ADDR_WIDTH'(n_q);
      end
    end
  end

`ifdef AGU_BOUNDS_CHECK_EN
  logic [2:0]  mode_q;
  logic [13:0] nn_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= '0;
      nn_q   <= '0;
    end else if (start_hit) begin
      mode_q <= agu_mode;
      nn_q   <= 14'(cfg_N) * 14'(cfg_N);
    end
  end

  // sticky until the next start; a bad start sets it in the same edge it clears
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      agu_err <= 1'b0;
    end else if (start_hit) begin
      agu_err <= start_bad;
    end else if (state == S_RUN && mode_q != MODE_WEIGHT &&
                 32'(addr_q) >= 32'(nn_q)) begin
      agu_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_address_gen_unit.sv
// Scoreboard bench for address_gen_unit: a loop-based reference model fills an
// expected-address queue per start; a negedge monitor pops and compares.
module tb_address_gen_unit;
  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          agu_start = 1'b0;
  logic          agu_enable = 1'b0;
  logic          addr_ready = 1'b0;
  logic [2:0]    agu_mode = '0;
  logic [6:0]    cfg_N = '0;
  logic [4:0]    cfg_K = '0;
  logic [6:0]    tile_row = '0;
  logic [6:0]    tile_col = '0;
  logic [AW-1:0] addr;
  logic          addr_valid, agu_done, agu_busy;
`ifdef AGU_BOUNDS_CHECK_EN
  logic          agu_err;
`endif

  int total = 0;
  int bad = 0;
  int exp_q[$];
  int cyc = 0;
  int start_cyc = 0;
  int done_cyc = -1;
  logic          pend_valid = 1'b0;
  logic [AW-1:0] pend_addr = '0;

  address_gen_unit dut (
    .clk(clk), .rst_n(rst_n), .agu_start(agu_start), .agu_enable(agu_enable),
    .agu_mode(agu_mode), .cfg_N(cfg_N), .cfg_K(cfg_K), .tile_row(tile_row),
    .tile_col(tile_col), .addr(addr), .addr_valid(addr_valid),
    .addr_ready(addr_ready), .agu_done(agu_done), .agu_busy(agu_busy)
`ifdef AGU_BOUNDS_CHECK_EN
    , .agu_err(agu_err)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic flag(input string name, input int act);
    total++;
    bad++;
    $display("FAIL %s: got %0d, nothing was expected", name, act);
  endtask

  // ---------------- reference model ----------------
  function automatic bit is_invalid(int mode, int n, int k, int tr, int tc);
    if (n == 0 || k == 0 || k > n || n > 64 || k > 16) return 1'b1;
    if (mode < 1 || mode > 4) return 1'b1;
    if (mode == 2 && (tr >= n || tc >= n)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int push_expected(int mode, int n, int k, int tr, int tc);
    int m, rr, cc, cnt;
    cnt = 0;
    m = n - k + 1;
    if (!is_invalid(mode, n, k, tr, tc)) begin
      case (mode)
        1: for (int i = 0; i < k * k; i++) begin exp_q.push_back(i % 4096); cnt++; end
        2: begin
          rr = (n - tr < 8) ? n - tr : 8;
          cc = (n - tc < 8) ? n - tc : 8;
          for (int r = 0; r < rr; r++)
            for (int c = 0; c < cc; c++) begin
              exp_q.push_back(((tr + r) * n + tc + c) % 4096); cnt++;
            end
        end
        3: for (int orow = 0; orow < m; orow++)
             for (int ocol = 0; ocol < m; ocol++)
               for (int kr = 0; kr < k; kr++)
                 for (int kc = 0; kc < k; kc++) begin
                   exp_q.push_back(((orow + kr) * n + ocol + kc) % 4096); cnt++;
                 end
        default: for (int i = 0; i < m * m; i++) begin exp_q.push_back(i % 4096); cnt++; end
      endcase
    end
    exp_q.push_back(-1);
    return cnt;
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    int e;
    if (!rst_n) begin
      pend_valid = 1'b0;
    end else begin
      if (addr_valid) begin
        if (pend_valid) check("stall_stable", 32'(addr), 32'(pend_addr));
        if (addr_ready && agu_enable) begin
          pend_valid = 1'b0;
          if (exp_q.size() == 0) flag("unexpected_addr", int'(addr));
          else begin
            e = exp_q.pop_front();
            if (e < 0) flag("addr_instead_of_done", int'(addr));
            else check("addr", 32'(addr), e);
          end
        end else begin
          pend_valid = 1'b1;
          pend_addr  = addr;
        end
      end
      if (agu_done) begin
        done_cyc = cyc;
        if (exp_q.size() == 0) flag("unexpected_done", 1);
        else begin
          e = exp_q.pop_front();
          check("done_position", e, -1);
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic drive(input int pat, input int i);
    case (pat)
      0: begin addr_ready = 1'b1; agu_enable = 1'b1; end
      1: begin addr_ready = (i % 2 == 0); agu_enable = (i % 7 != 3); end
      default: begin
        addr_ready = ($urandom_range(0, 3) != 0);
        agu_enable = ($urandom_range(0, 7) != 0);
      end
    endcase
  endtask

  task automatic start_only(input int mode, input int n, input int k, input int tr,
                            input int tc, input int pat, output int cnt, output bit inval);
    @(posedge clk); #1;
    agu_mode = 3'(mode); cfg_N = 7'(n); cfg_K = 5'(k);
    tile_row = 7'(tr); tile_col = 7'(tc);
    agu_start = 1'b1;
    done_cyc = -1;
    inval = is_invalid(mode, n, k, tr, tc);
    cnt = push_expected(mode, n, k, tr, tc);
    drive(pat, 0);
    @(posedge clk); #1;
    agu_start = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic wait_done(input int pat, input int cnt, input bit inval);
    int i;
    i = 1;
    while (exp_q.size() != 0 && i < 20000) begin
      drive(pat, i);
      @(posedge clk); #1;
      i++;
    end
    if (exp_q.size() != 0) begin
      flag("timeout_remaining", exp_q.size());
      exp_q.delete();
    end
    if (pat == 0) check("done_latency", done_cyc - start_cyc, inval ? 0 : cnt);
`ifdef AGU_BOUNDS_CHECK_EN
    check("agu_err", 32'(agu_err), 32'(inval));
`endif
  endtask

  task automatic run_seq(input int mode, input int n, input int k, input int tr,
                         input int tc, input int pat);
    int cnt;
    bit inval;
    start_only(mode, n, k, tr, tc, pat, cnt, inval);
    wait_done(pat, cnt, inval);
  endtask

  initial begin
    int cnt, mode, n, k, tr, tc;
    bit inval;
    #1;
    check("rst_addr", 32'(addr), 0);
    check("rst_valid", 32'(addr_valid), 0);
    check("rst_done", 32'(agu_done), 0);
    check("rst_busy", 32'(agu_busy), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    run_seq(1, 16, 3, 0, 0, 0);
    run_seq(2, 16, 3, 0, 8, 0);
    run_seq(2, 16, 3, 8, 12, 2);
    run_seq(3, 4, 3, 0, 0, 0);
    run_seq(4, 16, 3, 0, 0, 1);

    run_seq(3, 4, 5, 0, 0, 0);
    start_only(3, 4, 3, 0, 0, 0, cnt, inval);
`ifdef AGU_BOUNDS_CHECK_EN
    check("err_cleared", 32'(agu_err), 0);
`endif
    wait_done(0, cnt, inval);

    // reset in the middle of a COMPUTE run
    start_only(3, 4, 3, 0, 0, 2, cnt, inval);
    for (int i = 1; i < 12; i++) begin drive(2, i); @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    check("midrst_addr", 32'(addr), 0);
    check("midrst_valid", 32'(addr_valid), 0);
    check("midrst_done", 32'(agu_done), 0);
    check("midrst_busy", 32'(agu_busy), 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    start_only(3, 4, 3, 0, 0, 0, cnt, inval);
    check("restart_addr0", 32'(addr), 0);
    wait_done(0, cnt, inval);

    for (int r = 0; r < 25; r++) begin
      mode = $urandom_range(0, 5);
      n    = ($urandom_range(0, 15) == 0) ? 70 : $urandom_range(0, 9);
      k    = ($urandom_range(0, 15) == 0) ? 17 : $urandom_range(0, 5);
      tr   = $urandom_range(0, (n > 9) ? 9 : n);
      tc   = $urandom_range(0, (n > 9) ? 9 : n);
      run_seq(mode, n, k, tr, tc, $urandom_range(0, 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
